// File: rtl/mux2_to_1.sv
// -----------------------------------------------------------------------------
// mux2_to_1
// Parameterised 2:1 word multiplexer for datapath bypass/forwarding paths,
// for example choosing between a stored register-file value and same-cycle
// write data.
//
// Build option:
//   MUX2_TO_1_REG_OUT_EN  undefined (default): purely combinational, zero
//                         latency; clk and reset are ignored.
//                         defined: out is registered with exactly one cycle
//                         of latency and an asynchronous, active-high reset
//                         to RESET_VAL.
// The port list is the same in both builds.
// -----------------------------------------------------------------------------
module mux2_to_1 #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    // A zero-width datapath has no meaning; stop at elaboration.
    if (WIDTH < 1) begin : g_width_check
        $error("mux2_to_1: WIDTH must be at least 1");
    end

    // The conditional operator is used rather than and/or gating so that an
    // unknown sel gives X only on bits where in0 and in1 differ. Bits where
    // the inputs agree keep their common value.
    logic [WIDTH-1:0] w_mux;
    assign w_mux = sel ? in1 : in0;

`ifdef MUX2_TO_1_REG_OUT_EN

    logic [WIDTH-1:0] r_out;

    // Output register: loads every rising edge and has no enable. Reset forces
    // RESET_VAL at once and drops any value that was in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples its inputs from before the edge.
        if (reset) begin
            r_out <= RESET_VAL;
        end else begin
            r_out <= w_mux;
        end
    end

    assign out = r_out;

`else

    // The combinational build holds no state. clk and reset stay on the port
    // list so that both builds can be swapped without editing the parent.
    // They are folded into this sink so that it is clear they are unused here.
    logic w_unused_clk_reset;
    assign w_unused_clk_reset = ^{clk, reset, RESET_VAL};

    assign out = w_mux;

`endif

endmodule

// File: tb/tb_mux2_to_1.sv
// -----------------------------------------------------------------------------
// tb_mux2_to_1
// Directed bench for mux2_to_1 with a 32-bit and a 1-bit instance. It follows
// the same build option as the design (MUX2_TO_1_REG_OUT_EN). A reference
// model checks both outputs on every falling edge. Hand-computed literals pin
// the key cases.
// -----------------------------------------------------------------------------
module tb_mux2_to_1;

    logic        clk;
    logic        reset;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        sel;
    logic [31:0] out32;
    logic        a1;
    logic        b1;
    logic        s1;
    logic        out1;

    int n_vec  = 0;
    int n_miss = 0;
    bit cmp_en = 1'b0;

    mux2_to_1 #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .in0   (in0),
        .in1   (in1),
        .sel   (sel),
        .out   (out32)
    );

    mux2_to_1 #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .in0   (a1),
        .in1   (b1),
        .sel   (s1),
        .out   (out1)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison primitive: every check, from either process, passes through here.
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, want, $time);
        end
    endtask

    // Reference selection written as a bit mask, independent of the RTL.
    function automatic logic [31:0] pick(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
        logic [31:0] m;
        m = s ? 32'hFFFF_FFFF : 32'h0000_0000;
        return (b & m) | (a & ~m);
    endfunction

    logic [31:0] exp32;
    logic        exp1;

`ifdef MUX2_TO_1_REG_OUT_EN
    // Registered model: a history of the mux results sampled at each edge.
    // Reset empties the history, so nothing sampled before reset survives.
    logic [31:0] hist32[$];
    logic        hist1[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist32.delete();
            hist1.delete();
        end else begin
            hist32.push_back(pick(in0, in1, sel));
            hist1.push_back(pick({31'd0, a1}, {31'd0, b1}, s1) != 32'd0);
            if (hist32.size() > 4) void'(hist32.pop_front());
            if (hist1.size() > 4)  void'(hist1.pop_front());
        end
    end

    always_comb begin
        exp32 = 32'd0;
        exp1  = 1'b0;
        if (hist32.size() > 0) exp32 = hist32[hist32.size()-1];
        if (hist1.size() > 0)  exp1  = hist1[hist1.size()-1];
    end
`else
    // Combinational model: the output depends only on the current inputs.
    always_comb begin
        exp32 = pick(in0, in1, sel);
        exp1  = pick({31'd0, a1}, {31'd0, b1}, s1) != 32'd0;
    end
`endif

    // Compare process: on each falling edge, both outputs are checked against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model32", out32, exp32);
            check("model1", {31'd0, out1}, {31'd0, exp1});
        end
    end

    // Drives the inputs 1 unit after a rising edge and samples 1 unit later.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk);
        #1;
        in0 = a;
        in1 = b;
        sel = s;
        #1;
    endtask

    // Waits until a newly driven input is visible on the output.
    task automatic settle();
`ifdef MUX2_TO_1_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    // Truth table of a 1-bit mux indexed by {in0,in1,sel}.
    logic [7:0] tt1 = 8'hD8;

    initial begin
        reset = 1'b1;
        in0   = 32'd0;
        in1   = 32'd0;
        sel   = 1'b0;
        a1    = 1'b0;
        b1    = 1'b0;
        s1    = 1'b0;

`ifdef MUX2_TO_1_REG_OUT_EN
        // Reset is asserted before any clock edge, so out must already be 0.
        #2;
        check("reset_out32", out32, 32'd0);
        check("reset_out1", {31'd0, out1}, 32'd0);
        cmp_en = 1'b1;

        // Release reset. The new value appears only after the next rising edge.
        @(posedge clk);
        #1;
        reset = 1'b0;
        sel   = 1'b1;
        in1   = 32'h1234_5678;
        #1;
        check("no_load_before_edge", out32, 32'd0);
        @(posedge clk);
        #1;
        check("first_load", out32, 32'h1234_5678);

        // With sel alternating each cycle, out lags the inputs by one cycle.
        apply(32'hAAAA_0000, 32'h0000_BBBB, 1'b0);
        apply(32'h0000_0011, 32'h0000_0022, 1'b1);
        check("lag_sel0", out32, 32'hAAAA_0000);
        apply(32'h0000_0033, 32'h0000_0044, 1'b0);
        check("lag_sel1", out32, 32'h0000_0022);
        apply(32'h0000_0055, 32'h0000_0066, 1'b1);
        check("lag_sel0_b", out32, 32'h0000_0033);

        // Reset between edges clears out at once and drops the in-flight value.
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", out32, 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold", out32, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("load_after_reset", out32, 32'h0000_0066);
`else
        // In the combinational build, reset has no effect on out.
        #1;
        in0 = 32'h0000_1111;
        in1 = 32'hDEAD_BEEF;
        #1;
        check("reset_ignored", out32, 32'h0000_1111);
        reset  = 1'b0;
        cmp_en = 1'b1;

        apply(32'h0000_1111, 32'hDEAD_BEEF, 1'b0);
        check("sel0", out32, 32'h0000_1111);
        sel = 1'b1;
        #1;
        check("sel1_same_step", out32, 32'hDEAD_BEEF);

        // A change to in1 within the cycle shows on out immediately.
        apply(32'h0000_0000, 32'h0000_0001, 1'b1);
        check("track_pre", out32, 32'h0000_0001);
        in1 = 32'hFFFF_FFFF;
        #1;
        check("track_mid", out32, 32'hFFFF_FFFF);
        reset = 1'b1;
        #1;
        check("reset_toggle", out32, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("clk_toggle", out32, 32'hFFFF_FFFF);

        // When in0 equals in1, out holds that value whatever sel is.
        apply(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
        check("equal_sel0", out32, 32'hA5A5_A5A5);
        sel = 1'b1;
        #1;
        check("equal_sel1", out32, 32'hA5A5_A5A5);
        sel = 1'b0;
        #1;
        check("equal_sel0_again", out32, 32'hA5A5_A5A5);
`endif

        // Exhaustive truth table for the 1-bit instance.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v  = 3'(i);
            a1 = v[2];
            b1 = v[1];
            s1 = v[0];
            settle();
            check($sformatf("w1_tt%0d", i), {31'd0, out1}, {31'd0, tt1[i]});
        end

        // A few more varied words; the falling-edge model checks cover them.
        apply(32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
        apply(32'h8000_0001, 32'h7FFF_FFFE, 1'b0);
        apply(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
        apply(32'hCAFE_F00D, 32'h0BAD_C0DE, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Safety net so that the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished at t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
